// File: rtl/issue_pkg.sv
// rtl/issue_pkg.sv - shared opcode, tag constants and class helpers for the issue stage
package issue_pkg;

  localparam int TAG_W = 3;
  localparam int REG_W = 3;

  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LD  = 3'b010;
  localparam logic [2:0] OP_SD  = 3'b011;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_mem(input logic [2:0] op);
    return (op == OP_LD) || (op == OP_SD);
  endfunction

endpackage

// File: rtl/rs_tag_allocator.sv
// rtl/rs_tag_allocator.sv - busy bits and lowest-free tag encoder for one station class
module rs_tag_allocator
  import issue_pkg::*;
#(
  parameter int N    = 3,
  parameter int BASE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_i,
  input  logic             free_a_valid_i,
  input  logic [TAG_W-1:0] free_a_tag_i,
  input  logic             free_b_valid_i,
  input  logic [TAG_W-1:0] free_b_tag_i,
  output logic             any_free_o,
  output logic [TAG_W-1:0] free_tag_o
);

  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;
  logic [N-1:0] free_onehot;

  assign any_free_o = ~&busy_q;

  // Pick the lowest-numbered idle station; scanning downward lets the lowest index win.
  always_comb begin
    free_tag_o  = TAG_NONE;
    free_onehot = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_tag_o  = TAG_W'(BASE + i);
        free_onehot = '0;
        free_onehot[i] = 1'b1;
      end
    end
  end

  // Releases come from broadcasts outside this class's range too; those simply match nothing.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < N; i++) begin
      if (free_a_valid_i && (free_a_tag_i == TAG_W'(BASE + i))) busy_d[i] = 1'b0;
      if (free_b_valid_i && (free_b_tag_i == TAG_W'(BASE + i))) busy_d[i] = 1'b0;
    end
    if (alloc_i) busy_d = busy_d | free_onehot;
  end

  // Busy bit register.
  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

endmodule

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - Tomasulo issue stage with rename table; ISSUE_STATS_EN adds issue/stall counters
module issue_unit
  import issue_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int N_ALU_RS = 3,
  parameter int N_MEM_RS = 2,
  parameter int NUM_REGS = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [2:0]        opcode,
  input  logic [2:0]        RX,
  input  logic [2:0]        RY,
  input  logic [2:0]        RZ,
  input  logic [3:0]        immediate,
  output logic              stall,
  output logic [2:0]        rf_addr_a,
  output logic [2:0]        rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic              cdb_valid,
  input  logic [2:0]        cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              mem_done_valid,
  input  logic [2:0]        mem_done_tag,
  output logic              iss_valid,
  output logic [2:0]        iss_op,
  output logic [2:0]        iss_tag,
  output logic [DATA_W-1:0] iss_vj,
  output logic [DATA_W-1:0] iss_vk,
  output logic [2:0]        iss_qj,
  output logic [2:0]        iss_qk,
  output logic [3:0]        iss_imm
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]       issued_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  logic             op_alu, op_mem, op_legal;
  logic             alu_free, mem_free;
  logic [TAG_W-1:0] alu_tag, mem_tag, new_tag;
  logic             accept, writes_dest;
  logic [TAG_W-1:0] stat_j, stat_k;
  logic [DATA_W-1:0] vj, vk;
  logic [TAG_W-1:0] qj, qk;

  logic [TAG_W-1:0] status_q [NUM_REGS];
  logic [TAG_W-1:0] status_d [NUM_REGS];

  logic              iss_valid_q;
  logic [2:0]        iss_op_q;
  logic [TAG_W-1:0]  iss_tag_q;
  logic [DATA_W-1:0] iss_vj_q, iss_vk_q;
  logic [TAG_W-1:0]  iss_qj_q, iss_qk_q;
  logic [3:0]        iss_imm_q;

  assign op_alu   = is_alu(opcode);
  assign op_mem   = is_mem(opcode);
  assign op_legal = op_alu | op_mem;

  assign stall  = instr_valid & ~reset & ((op_alu & ~alu_free) | (op_mem & ~mem_free));
  assign accept = instr_valid & ~stall & ~reset & op_legal;
  assign writes_dest = accept & (op_alu | (opcode == OP_LD));
  assign new_tag = op_alu ? alu_tag : mem_tag;

  // Stores read their data register through the k port; everything else reads RZ there.
  assign rf_addr_a = RY;
  assign rf_addr_b = (opcode == OP_SD) ? RX : RZ;

  rs_tag_allocator #(.N(N_ALU_RS), .BASE(1)) u_alu_alloc (
    .clock          (clock),
    .reset          (reset),
    .alloc_i        (accept & op_alu),
    .free_a_valid_i (cdb_valid),
    .free_a_tag_i   (cdb_tag),
    .free_b_valid_i (1'b0),
    .free_b_tag_i   (TAG_NONE),
    .any_free_o     (alu_free),
    .free_tag_o     (alu_tag)
  );

  rs_tag_allocator #(.N(N_MEM_RS), .BASE(N_ALU_RS + 1)) u_mem_alloc (
    .clock          (clock),
    .reset          (reset),
    .alloc_i        (accept & op_mem),
    .free_a_valid_i (cdb_valid),
    .free_a_tag_i   (cdb_tag),
    .free_b_valid_i (mem_done_valid),
    .free_b_tag_i   (mem_done_tag),
    .any_free_o     (mem_free),
    .free_tag_o     (mem_tag)
  );

  // Resolve each source: ready in the file, caught from this cycle's broadcast, or renamed.
  always_comb begin
    stat_j = status_q[rf_addr_a];
    stat_k = status_q[rf_addr_b];
    vj = '0;
    qj = stat_j;
    if (stat_j == TAG_NONE) begin
      vj = rf_data_a;
    end else if (cdb_valid && (cdb_tag == stat_j)) begin
      vj = cdb_data;
      qj = TAG_NONE;
    end
    vk = '0;
    qk = stat_k;
    if (stat_k == TAG_NONE) begin
      vk = rf_data_b;
    end else if (cdb_valid && (cdb_tag == stat_k)) begin
      vk = cdb_data;
      qk = TAG_NONE;
    end
    if (opcode == OP_LD) begin
      vk = '0;
      qk = TAG_NONE;
    end
  end

  // Broadcast clears matching producers first so a same-edge rename of that register wins.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      status_d[r] = status_q[r];
      if (cdb_valid && (cdb_tag != TAG_NONE) && (status_q[r] == cdb_tag)) status_d[r] = TAG_NONE;
      if (writes_dest && (RX == REG_W'(r))) status_d[r] = new_tag;
    end
  end

  // Register status table.
  always_ff @(posedge clock) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset) status_q[r] <= TAG_NONE;
      else       status_q[r] <= status_d[r];
    end
  end

  // Issue packet register; valid is a single-cycle pulse, fields hold between issues.
  always_ff @(posedge clock) begin
    if (reset) begin
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_tag_q   <= '0;
      iss_vj_q    <= '0;
      iss_vk_q    <= '0;
      iss_qj_q    <= '0;
      iss_qk_q    <= '0;
      iss_imm_q   <= '0;
    end else begin
      iss_valid_q <= accept;
      if (accept) begin
        iss_op_q  <= opcode;
        iss_tag_q <= new_tag;
        iss_vj_q  <= vj;
        iss_vk_q  <= vk;
        iss_qj_q  <= qj;
        iss_qk_q  <= qk;
        iss_imm_q <= immediate;
      end
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_op    = iss_op_q;
  assign iss_tag   = iss_tag_q;
  assign iss_vj    = iss_vj_q;
  assign iss_vk    = iss_vk_q;
  assign iss_qj    = iss_qj_q;
  assign iss_qk    = iss_qk_q;
  assign iss_imm   = iss_imm_q;

`ifdef ISSUE_STATS_EN
  logic [15:0] issued_cnt_q;
  logic [15:0] stall_cnt_q;

  // Saturating issue and stall-cycle counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (iss_valid_q && (issued_cnt_q != 16'hFFFF)) issued_cnt_q <= issued_cnt_q + 16'd1;
      if (stall && (stall_cnt_q != 16'hFFFF))        stall_cnt_q  <= stall_cnt_q + 16'd1;
    end
  end

  assign issued_cnt = issued_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - directed vector bench for issue_unit
module tb_issue_unit;
  import issue_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [2:0]  opcode = '0, RX = '0, RY = '0, RZ = '0;
  logic [3:0]  immediate = '0;
  logic        stall;
  logic [2:0]  rf_addr_a, rf_addr_b;
  logic [15:0] rf_data_a, rf_data_b;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic        mem_done_valid = 1'b0;
  logic [2:0]  mem_done_tag = '0;
  logic        iss_valid;
  logic [2:0]  iss_op, iss_tag, iss_qj, iss_qk;
  logic [15:0] iss_vj, iss_vk;
  logic [3:0]  iss_imm;
`ifdef ISSUE_STATS_EN
  logic [15:0] issued_cnt, stall_cnt;
`endif

  logic [15:0] rf [8];
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  always #5 clock = ~clock;

  issue_unit #(.DATA_W(16), .N_ALU_RS(3), .N_MEM_RS(2), .NUM_REGS(8)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .RX(RX), .RY(RY), .RZ(RZ), .immediate(immediate), .stall(stall),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .mem_done_valid(mem_done_valid), .mem_done_tag(mem_done_tag),
    .iss_valid(iss_valid), .iss_op(iss_op), .iss_tag(iss_tag), .iss_vj(iss_vj), .iss_vk(iss_vk),
    .iss_qj(iss_qj), .iss_qk(iss_qk), .iss_imm(iss_imm)
`ifdef ISSUE_STATS_EN
    , .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    bit          rst, iv;
    logic [2:0]  op, rx, ry, rz;
    logic [3:0]  imm;
    bit          cv;
    logic [2:0]  ct;
    logic [15:0] cd;
    bit          mv;
    logic [2:0]  mt;
    bit          e_stall, e_val;
    logic [2:0]  e_tag;
    logic [15:0] e_vj, e_vk;
    logic [2:0]  e_qj, e_qk;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, input bit iv, input logic [2:0] op,
                              input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] rz,
                              input logic [3:0] imm, input bit cv, input logic [2:0] ct,
                              input logic [15:0] cd, input bit mv, input logic [2:0] mt,
                              input bit es, input bit ev, input logic [2:0] et,
                              input logic [15:0] evj, input logic [15:0] evk,
                              input logic [2:0] eqj, input logic [2:0] eqk);
    vec_t v;
    v.rst = rst; v.iv = iv; v.op = op; v.rx = rx; v.ry = ry; v.rz = rz; v.imm = imm;
    v.cv = cv; v.ct = ct; v.cd = cd; v.mv = mv; v.mt = mt;
    v.e_stall = es; v.e_val = ev; v.e_tag = et; v.e_vj = evj; v.e_vk = evk;
    v.e_qj = eqj; v.e_qk = eqk;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t v, input string id);
    @(negedge clock);
    reset = v.rst; instr_valid = v.iv; opcode = v.op; RX = v.rx; RY = v.ry; RZ = v.rz;
    immediate = v.imm; cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd;
    mem_done_valid = v.mv; mem_done_tag = v.mt;
    #1;
    check({id, " stall"}, {31'b0, stall}, {31'b0, v.e_stall});
    @(posedge clock);
    #1;
    check({id, " iss_valid"}, {31'b0, iss_valid}, {31'b0, v.e_val});
    if (v.e_val) begin
      check({id, " tag"}, {29'b0, iss_tag}, {29'b0, v.e_tag});
      check({id, " op"},  {29'b0, iss_op},  {29'b0, v.op});
      check({id, " vj"},  {16'b0, iss_vj},  {16'b0, v.e_vj});
      check({id, " vk"},  {16'b0, iss_vk},  {16'b0, v.e_vk});
      check({id, " qj"},  {29'b0, iss_qj},  {29'b0, v.e_qj});
      check({id, " qk"},  {29'b0, iss_qk},  {29'b0, v.e_qk});
      check({id, " imm"}, {28'b0, iss_imm}, {28'b0, v.imm});
    end
    if (v.rst) begin
      check({id, " rst tag"}, {29'b0, iss_tag}, 32'd0);
      check({id, " rst vj"},  {16'b0, iss_vj},  32'd0);
      check({id, " rst qk"},  {29'b0, iss_qk},  32'd0);
    end
  endtask

  function automatic vec_t rrow();
    return mk(1,0,0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0,0,0);
  endfunction

  initial begin
    rf[0] = 16'd3; rf[1] = 16'd5; rf[2] = 16'd7; rf[3] = 16'd11;
    rf[4] = 16'd24; rf[5] = 16'd25; rf[6] = 16'd26; rf[7] = 16'd27;

    // ADD R0,R1,R2 then dependent SUB R1,R0,R1
    tbl.push_back(rrow());
    tbl.push_back(mk(0,1,OP_ADD,0,1,2,0, 0,0,0, 0,0, 0,1,1,5,7,0,0));
    tbl.push_back(mk(0,1,OP_SUB,1,0,1,0, 0,0,0, 0,0, 0,1,2,0,5,1,0));
    // Fill the ALU class, stall, free tag 2 via CDB, resume
    tbl.push_back(rrow());
    tbl.push_back(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,1,5,7,0,0));
    tbl.push_back(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,2,5,7,0,0));
    tbl.push_back(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,3,5,7,0,0));
    tbl.push_back(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,OP_ADD,3,1,2,0, 1,2,99, 0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,2,5,7,0,0));
    // Illegal opcode never stalls even with the ALU class full
    tbl.push_back(mk(0,1,3'b111,0,1,2,0, 0,0,0, 0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,OP_ADD,5,0,2,0, 0,0,0, 0,0, 1,0,0,0,0,0,0));
    // Illegal op leaves no allocation or rename behind
    tbl.push_back(rrow());
    tbl.push_back(mk(0,1,3'b100,0,1,2,0, 0,0,0, 0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,OP_ADD,1,0,2,0, 0,0,0, 0,0, 0,1,1,3,7,0,0));
    // LD then SD with same-cycle CDB bypass on both operands
    tbl.push_back(rrow());
    tbl.push_back(mk(0,1,OP_LD,1,2,0,1, 0,0,0, 0,0, 0,1,4,7,0,0,0));
    tbl.push_back(mk(0,1,OP_SD,1,1,0,1, 1,4,9, 0,0, 0,1,5,9,9,0,0));
    // Fill MEM class, stall, free tag 4 via mem_done, resume
    tbl.push_back(rrow());
    tbl.push_back(mk(0,1,OP_LD,2,0,0,0, 0,0,0, 0,0, 0,1,4,3,0,0,0));
    tbl.push_back(mk(0,1,OP_SD,2,3,0,2, 0,0,0, 0,0, 0,1,5,11,0,0,4));
    tbl.push_back(mk(0,1,OP_LD,4,0,0,0, 0,0,0, 0,0, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,OP_LD,4,0,0,0, 0,0,0, 1,4, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,OP_LD,4,0,0,0, 0,0,0, 0,0, 0,1,4,3,0,0,0));
    // Same-edge CDB and rename of R0: new tag wins; freed tag 1 reused next
    tbl.push_back(rrow());
    tbl.push_back(mk(0,1,OP_ADD,0,1,2,0, 0,0,0, 0,0, 0,1,1,5,7,0,0));
    tbl.push_back(mk(0,1,OP_ADD,0,1,2,0, 1,1,50, 0,0, 0,1,2,5,7,0,0));
    tbl.push_back(mk(0,1,OP_ADD,5,0,0,0, 0,0,0, 0,0, 0,1,1,0,0,2,2));
    // CDB tag 0 and mem_done of an ALU tag are both ignored
    tbl.push_back(mk(0,1,OP_ADD,6,5,0,0, 1,0,77, 1,1, 0,1,3,0,0,1,2));
    tbl.push_back(mk(0,1,OP_ADD,7,1,2,0, 0,0,0, 0,0, 1,0,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], $sformatf("v%0d", i));

    // Reset mid-operation with the ALU class full: no stall under reset, all tags and renames freed
    apply_row(rrow(), "m0");
    apply_row(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,1,5,7,0,0), "m1");
    apply_row(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,2,5,7,0,0), "m2");
    apply_row(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,3,5,7,0,0), "m3");
    apply_row(mk(1,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,0,0,0,0,0,0), "m4");
    apply_row(mk(0,1,OP_ADD,4,3,2,0, 0,0,0, 0,0, 0,1,1,11,7,0,0), "m5");
    apply_row(mk(0,0,OP_ADD,4,3,2,0, 0,0,0, 0,0, 0,0,0,0,0,0,0), "m6");
    apply_row(mk(0,1,OP_ADD,5,4,3,0, 0,0,0, 0,0, 0,1,2,0,11,1,0), "m7");

`ifdef ISSUE_STATS_EN
    // Counters over: 3 issues, 2 stall cycles, 1 more issue, 1 idle cycle
    apply_row(rrow(), "s0");
    check("s0 issued_cnt", {16'b0, issued_cnt}, 32'd0);
    check("s0 stall_cnt",  {16'b0, stall_cnt},  32'd0);
    apply_row(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,1,5,7,0,0), "s1");
    apply_row(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,2,5,7,0,0), "s2");
    apply_row(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,3,5,7,0,0), "s3");
    apply_row(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 1,0,0,0,0,0,0), "s4");
    apply_row(mk(0,1,OP_ADD,3,1,2,0, 1,2,99, 0,0, 1,0,0,0,0,0,0), "s5");
    apply_row(mk(0,1,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,1,2,5,7,0,0), "s6");
    apply_row(mk(0,0,OP_ADD,3,1,2,0, 0,0,0, 0,0, 0,0,0,0,0,0,0), "s7");
    check("s7 issued_cnt", {16'b0, issued_cnt}, 32'd4);
    check("s7 stall_cnt",  {16'b0, stall_cnt},  32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Tomasulo issue stage directly downstream of the instruction queue.
- Consumes the queue's registered opcode/RX/RY/RZ/immediate fields, allocates a reservation-station (RS) tag, and reads or renames source operands via an internal register status table.
- Emits one registered issue packet per accepted instruction.
- Drives the queue's stall input when no RS slot of the required class is free.

Parameters:
- DATA_W, 16, operand/CDB data width
- N_ALU_RS, 3, ADD/SUB stations; tags 1..N_ALU_RS
- N_MEM_RS, 2, LD/SD buffers; tags N_ALU_RS+1..N_ALU_RS+N_MEM_RS; sum must be ≤7
- NUM_REGS, 8, architectural registers

Ports:
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  queue output fields hold an un-issued instruction
- opcode  in  3  000 ADD, 001 SUB, 010 LD, 011 SD, 1xx illegal
- RX, RY, RZ  in  3 each  register fields
- immediate  in  4  LD/SD offset
- stall  out  1  combinational; 1 = queue must hold
- rf_addr_a, rf_addr_b  out  3 each  register file read addresses (combinational)
- rf_data_a, rf_data_b  in  DATA_W each  register file read data, same cycle
- cdb_valid  in  1  common data bus broadcast valid
- cdb_tag  in  3  producing tag
- cdb_data  in  DATA_W  result value
- mem_done_valid  in  1  store completed (SD does not broadcast)
- mem_done_tag  in  3  tag of completed store
- iss_valid  out  1  issue packet valid, one-cycle pulse
- iss_op  out  3  opcode
- iss_tag  out  3  allocated tag
- iss_vj, iss_vk  out  DATA_W each  operand values
- iss_qj, iss_qk  out  3 each  pending producer tags; 0 = value valid
- iss_imm  out  4  immediate

Behaviour:
- Reset: all iss_* outputs 0, busy bits cleared, all register status entries 0, stats counters 0. stall is 0 while reset is asserted.
- Operand mapping:
  - ADD/SUB: dest RX; j=RY, k=RZ.
  - LD: dest RX; j=RY (base); k unused (qk=0, vk=0).
  - SD: no dest; j=RY (base); k=RX (store data).
  - rf_addr_a drives the j register; rf_addr_b drives the k register.
- Class and stall:
  - ADD/SUB need a free ALU tag; LD/SD need a free MEM tag.
  - stall = instr_valid & ~reset & (no free tag in the class).
  - Illegal opcodes never stall.
- Accept: an instruction is accepted when instr_valid & ~stall. Illegal opcodes are accepted and dropped, with no packet.
- Allocation: lowest-numbered free tag in the class; its busy bit is set at the accepting edge.
- Latency: iss_valid rises at the edge after acceptance (1 cycle) and holds for 1 cycle. With continuous input and free slots, throughput is 1 issue/cycle.
- Operand resolution, per source:
  - Status[reg]==0 → V=rf_data, Q=0.
  - Status[reg]==cdb_tag & cdb_valid (same cycle) → V=cdb_data, Q=0 (bypass).
  - Otherwise → Q=Status[reg], V=0.
- Rename: for ADD/SUB/LD, Status[RX] ← allocated tag at the accepting edge. A source equal to RX uses the old status.
- CDB: when cdb_valid, the busy bit of cdb_tag clears and every Status entry equal to cdb_tag clears.
  - If the same edge renames that register, the new tag wins.
  - A freed slot becomes allocatable in the next cycle only; stall uses pre-edge busy bits.
- mem_done: clears the busy bit of mem_done_tag; no status update.
- Busy tag 0, or CDB/mem_done carrying tag 0 or an unallocated tag: ignored.
- Reset mid-operation: pending packet discarded, all tags freed, no partial state survives.

Optional Feature:
- ISSUE_STATS_EN defined:
  - Adds outputs issued_cnt (16) and stall_cnt (16).
  - issued_cnt increments per iss_valid; stall_cnt increments per cycle with stall=1.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: the ports and counters are absent.

Decomposition:
- Package issue_pkg:
  - opcode constants OP_ADD/OP_SUB/OP_LD/OP_SD
  - TAG_NONE=0
  - tag width 3
  - is_alu/is_mem helper functions
- Sub-module rs_tag_allocator (instantiated twice, ALU and MEM):
  - holds busy bits
  - find-first-free encoder, any_free flag
  - set on allocate; clear on free

Test Plan:
1. Reset, then ADD R0,R1,R2 with all status 0, rf=5/7 → next cycle iss_valid=1, tag=1, vj=5, vk=7, qj=qk=0; Status[R0]=1.
2. ADD R0,R1,R2 then SUB R1,R0,R1 back-to-back → SUB tag=2, qj=1, vk=rf R1; Status[R1]=2.
3. Four ADDs with no CDB → tags 1, 2, 3 issued; stall=1 on 4th. cdb_valid tag=2 → stall drops the next cycle and the 4th ADD gets tag 2.
4. LD R1,1(R2) pending (tag 4), then SD R1,1(R1) while cdb_valid tag=4 data=9 in the same cycle → SD qk=0, vk=9, qj=0, vj=9; tag=5.
5. Three LD/SD with mem_done never asserted → stall on 3rd. mem_done tag=4 → issue resumes with tag 4.
6. Opcode 3'b111 with instr_valid → no stall, no iss_valid, state unchanged. With ISSUE_STATS_EN: issued_cnt and stall_cnt match scenario 3 (4 issued, 1+ stall cycles).
